// File: rtl/mem_stage_pkg.sv
// Shared encodings and the load lane-extract/extend helper for the MEM stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam int LANES = 4;
    localparam int CNT_W = 3;

    // Picks the addressed byte/half out of a little-endian word and extends it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{b[7] & ~is_unsigned}}, b};
            SZ_HALF: r = {{16{h[15] & ~is_unsigned}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_stage_data_mem_be.sv
// Word-wide data memory with per-byte write enables and asynchronous read.
module data_mem_be #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    // NOTE: the array has no reset; clearing a RAM would force it into flops.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: branch decision, wait-stated byte-lane memory access and
// the MEM/WB pipeline register, with a stall to freeze upstream while waiting.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int REG_W       = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [1:0]        ctrl_wb,
    input  logic              branch,
    input  logic              branch_ne,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic [REG_W-1:0]  write_reg,
    output logic              stall,
    output logic              pc_src,
    output logic              wb_valid,
    output logic [1:0]        wb_ctrl,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [REG_W-1:0]  wb_write_reg,
    output logic              wb_misaligned
);

    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_op, misaligned, aligned_op, mem_we;
    logic [LANES-1:0]  be;
    logic [31:0]       wr_word, rd_word, ld_data;
    logic [ADDR_W-1:0] word_idx;
    logic              addr_unused;

    logic              wb_valid_q, wb_misaligned_q;
    logic [1:0]        wb_ctrl_q;
    logic [DATA_W-1:0] wb_read_data_q, wb_alu_result_q;
    logic [REG_W-1:0]  wb_write_reg_q;

    assign pc_src      = in_valid & branch & (alu_zero ^ branch_ne);
    assign mem_op      = in_valid & (mem_read | mem_write);
    assign word_idx    = address[ADDR_W+1:2];
    assign addr_unused = ^address[DATA_W-1:ADDR_W+2];

    always_comb begin
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = address[0];
            default: misaligned = |address[1:0];
        endcase
        misaligned = misaligned & mem_op;
    end

    assign aligned_op = mem_op & ~misaligned;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aligned_op && WAIT_CYCLES > 0) begin
                    stall   = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset releases the pipeline at once, even with a request held on the inputs.
        if (!RST) stall = 1'b0;
    end

    // Stores are treated as word-replicated data masked by lane enables.
    always_comb begin
        be      = '0;
        wr_word = write_data;
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << address[1:0];
                wr_word = {4{write_data[7:0]}};
            end
            SZ_HALF: begin
                be      = address[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{write_data[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    // A store wins when both read and write are requested.
    assign mem_we = RST & ~stall & aligned_op & mem_write;

    data_mem_be #(.ADDR_W(ADDR_W)) u_data_mem (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .be_i    (be),
        .addr_i  (word_idx),
        .wdata_i (wr_word),
        .rdata_o (rd_word)
    );

    assign ld_data = load_extend(rd_word, address[1:0], size, load_unsigned);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            wb_valid_q      <= 1'b0;
            wb_ctrl_q       <= '0;
            wb_read_data_q  <= '0;
            wb_alu_result_q <= '0;
            wb_write_reg_q  <= '0;
            wb_misaligned_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall) begin
                wb_valid_q <= 1'b0;
                wb_ctrl_q  <= '0;
            end else begin
                wb_valid_q      <= in_valid;
                wb_ctrl_q       <= misaligned ? 2'b00 : ctrl_wb;
                wb_read_data_q  <= ld_data;
                wb_alu_result_q <= address;
                wb_write_reg_q  <= write_reg;
                wb_misaligned_q <= misaligned;
            end
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_ctrl       = wb_ctrl_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_misaligned = wb_misaligned_q;

endmodule
